// File: rtl/pipearch_program_sequencer_pkg.sv
// Shared types and constants for the program sequencer: machine states,
// sequencer opcodes, header geometry and program-memory sizing.
package pipearch_program_sequencer_pkg;

    localparam int SEQ_HEADER_WIDTH  = 32;
    localparam int LOG2_PROGRAM_SIZE = 5;
    localparam int PROGRAM_SIZE      = 1 << LOG2_PROGRAM_SIZE;
    localparam int REGS_WIDTH        = 384;
    localparam int LOOP_COUNT_WIDTH  = 16;

    typedef enum logic [2:0] {
        IDLE                = 3'd0,
        INSTRUCTION_FETCH   = 3'd1,
        INSTRUCTION_RECEIVE = 3'd2,
        INSTRUCTION_DECODE  = 3'd3,
        EXECUTE             = 3'd4,
        DONE                = 3'd5
    } t_machinestate;

    typedef enum logic [7:0] {
        END  = 8'h00,
        JUMP = 8'h01
    } t_seq_opcode;

endpackage

// File: rtl/pipearch_seq_loop_counter.sv
// Loop iteration counter used by JUMP instructions: clear has priority over
// load, load over increment.
module pipearch_seq_loop_counter
    import pipearch_program_sequencer_pkg::*;
#(
    parameter int WIDTH = LOOP_COUNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             incr,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (incr) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipearch_program_sequencer.sv
// Program sequencer: fetches instructions from program memory, decodes the
// sequencer opcodes (END, JUMP) and hands every other instruction to the
// datapath, waiting for its completion pulse before moving on.
// Optional feature: define PIPEARCH_SEQ_LOOP_EN to give JUMP counted-loop
// semantics; without it JUMP is an illegal instruction.
module pipearch_program_sequencer
    import pipearch_program_sequencer_pkg::*;
#(
    parameter int INSTR_WIDTH = SEQ_HEADER_WIDTH + REGS_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    start,
    input  logic [LOG2_PROGRAM_SIZE:0]              program_length,
    output logic                                    prog_re,
    output logic [LOG2_PROGRAM_SIZE-1:0]            prog_raddr,
    input  logic [INSTR_WIDTH-1:0]                  prog_rdata,
    input  logic                                    prog_rvalid,
    output logic                                    exec_start,
    output logic [7:0]                              exec_opcode,
    output logic [INSTR_WIDTH-SEQ_HEADER_WIDTH-1:0] exec_regs,
    input  logic                                    exec_done,
    output logic [2:0]                              state,
    output logic [LOG2_PROGRAM_SIZE-1:0]            pc,
    output logic                                    done,
    output logic                                    error
);

    localparam int PAYLOAD_WIDTH = INSTR_WIDTH - SEQ_HEADER_WIDTH;
    localparam logic [LOG2_PROGRAM_SIZE:0] LENGTH_MAX = (LOG2_PROGRAM_SIZE+1)'(PROGRAM_SIZE);

    t_machinestate                state_q, state_d;
    logic [LOG2_PROGRAM_SIZE-1:0] pc_q, pc_d;
    logic [LOG2_PROGRAM_SIZE:0]   length_q, length_d;
    logic                         error_q, error_d;
    logic                         prog_re_q, exec_start_q, done_q;
    logic [7:0]                   opcode_q;
    logic [PAYLOAD_WIDTH-1:0]     regs_q;

    logic [LOG2_PROGRAM_SIZE:0]   length_in;
    logic [LOG2_PROGRAM_SIZE:0]   pc_plus;
    logic                         last_instr;

`ifdef PIPEARCH_SEQ_LOOP_EN
    logic [LOG2_PROGRAM_SIZE-1:0] jump_target_q;
    logic [LOOP_COUNT_WIDTH-1:0]  jump_count_q;
    logic [LOOP_COUNT_WIDTH-1:0]  loop_count;
    logic                         loop_incr, loop_clear;
    logic                         unused_header;

    assign unused_header = ^prog_rdata[15:13];

    pipearch_seq_loop_counter #(
        .WIDTH(LOOP_COUNT_WIDTH)
    ) u_loop_counter (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (1'b0),
        .load_value('0),
        .incr      (loop_incr),
        .clear     (loop_clear),
        .count     (loop_count)
    );
`else
    logic unused_header;

    assign unused_header = ^prog_rdata[SEQ_HEADER_WIDTH-1:8];
`endif

    // Oversized lengths clamp to the program memory size.
    assign length_in  = (program_length > LENGTH_MAX) ? LENGTH_MAX : program_length;
    assign pc_plus    = {1'b0, pc_q} + 1'b1;
    assign last_instr = (pc_plus == length_q);

    // next-state, program counter, length and error flag
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        length_d = length_q;
        error_d  = error_q;
`ifdef PIPEARCH_SEQ_LOOP_EN
        loop_incr  = 1'b0;
        loop_clear = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d     = '0;
                    length_d = length_in;
                    error_d  = 1'b0;
`ifdef PIPEARCH_SEQ_LOOP_EN
                    loop_clear = 1'b1;
`endif
                    state_d = (length_in == '0) ? DONE : INSTRUCTION_FETCH;
                end
            end
            INSTRUCTION_FETCH: state_d = INSTRUCTION_RECEIVE;
            INSTRUCTION_RECEIVE: begin
                if (prog_rvalid) state_d = INSTRUCTION_DECODE;
            end
            INSTRUCTION_DECODE: begin
                if (opcode_q == END) begin
                    state_d = DONE;
                end else if (opcode_q == JUMP) begin
`ifdef PIPEARCH_SEQ_LOOP_EN
                    if ({1'b0, jump_target_q} >= length_q) begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end else if (loop_count < jump_count_q) begin
                        loop_incr = 1'b1;
                        pc_d      = jump_target_q;
                        state_d   = INSTRUCTION_FETCH;
                    end else begin
                        // Loop exhausted (or count 0): fall through to pc+1.
                        loop_clear = 1'b1;
                        if (last_instr) begin
                            state_d = DONE;
                        end else begin
                            pc_d    = pc_plus[LOG2_PROGRAM_SIZE-1:0];
                            state_d = INSTRUCTION_FETCH;
                        end
                    end
`else
                    error_d = 1'b1;
                    state_d = DONE;
`endif
                end else begin
                    state_d = EXECUTE;
                end
            end
            EXECUTE: begin
                // A completion pulse in the launch cycle belongs to nothing.
                if (exec_done && !exec_start_q) begin
                    if (last_instr) begin
                        state_d = DONE;
                    end else begin
                        pc_d    = pc_plus[LOG2_PROGRAM_SIZE-1:0];
                        state_d = INSTRUCTION_FETCH;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // control state and registered strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            length_q     <= '0;
            error_q      <= 1'b0;
            prog_re_q    <= 1'b0;
            exec_start_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            length_q     <= length_d;
            error_q      <= error_d;
            prog_re_q    <= (state_d == INSTRUCTION_FETCH);
            exec_start_q <= (state_d == EXECUTE) && (state_q != EXECUTE);
            done_q       <= (state_q == DONE);
        end
    end

    // instruction latch, loaded when the memory response arrives
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opcode_q <= '0;
            regs_q   <= '0;
`ifdef PIPEARCH_SEQ_LOOP_EN
            jump_target_q <= '0;
            jump_count_q  <= '0;
`endif
        end else if (state_q == INSTRUCTION_RECEIVE && prog_rvalid) begin
            opcode_q <= prog_rdata[7:0];
            regs_q   <= prog_rdata[INSTR_WIDTH-1:SEQ_HEADER_WIDTH];
`ifdef PIPEARCH_SEQ_LOOP_EN
            jump_target_q <= prog_rdata[8 +: LOG2_PROGRAM_SIZE];
            jump_count_q  <= prog_rdata[31:16];
`endif
        end
    end

    assign prog_re     = prog_re_q;
    assign prog_raddr  = pc_q;
    assign exec_start  = exec_start_q;
    assign exec_opcode = opcode_q;
    assign exec_regs   = regs_q;
    assign state       = state_q;
    assign pc          = pc_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_pipearch_program_sequencer.sv
// Self-checking bench for pipearch_program_sequencer: directed vector table,
// hand-written timing/reset sequences and random programs against a
// program-level reference model.
module tb_pipearch_program_sequencer;
    import pipearch_program_sequencer_pkg::*;

    localparam int IW = SEQ_HEADER_WIDTH + REGS_WIDTH;
    localparam int AW = LOG2_PROGRAM_SIZE;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [AW:0]       program_length = '0;
    logic              prog_re;
    logic [AW-1:0]     prog_raddr;
    logic [IW-1:0]     prog_rdata = '0;
    logic              prog_rvalid = 1'b0;
    logic              exec_start;
    logic [7:0]        exec_opcode;
    logic [REGS_WIDTH-1:0] exec_regs;
    logic              exec_done;
    logic              exec_done_resp = 1'b0;
    logic              exec_done_inj = 1'b0;
    logic [2:0]        state;
    logic [AW-1:0]     pc;
    logic              done;
    logic              error;

    assign exec_done = exec_done_resp | exec_done_inj;

    pipearch_program_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .program_length(program_length),
        .prog_re       (prog_re),
        .prog_raddr    (prog_raddr),
        .prog_rdata    (prog_rdata),
        .prog_rvalid   (prog_rvalid),
        .exec_start    (exec_start),
        .exec_opcode   (exec_opcode),
        .exec_regs     (exec_regs),
        .exec_done     (exec_done),
        .state         (state),
        .pc            (pc),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;

    logic [IW-1:0] mem [PROGRAM_SIZE];
    logic [31:0]   pl_seed = 32'h0;
    int            rd_lat = 0;
    int            exec_lat = 2;

    int n_checks = 0;
    int n_fail = 0;

    // monitor counters (written only by the monitor)
    int n_exec = 0, n_fetch = 0, n_done = 0, n_recv = 0, n_execcyc = 0;
    int n_regs_bad = 0, n_addr_bad = 0;
    int exec_pcs[$];

    int b_exec, b_fetch, b_done, b_recv, b_execcyc, b_regs_bad, b_addr_bad, b_pcs;
    int d_exec, d_fetch, d_done, d_recv, d_execcyc, d_regs_bad, d_addr_bad;

    int model_pcs[$];
    bit model_err;
    int model_last;
    int model_fetches;

    typedef struct {
        int          len;
        logic [3:0][31:0] hdr;
        int          execs;
        int          fetches;
        int          err;
        int          last_pc;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void set_instr(input int idx, input logic [31:0] hdr);
        logic [31:0] w;
        w = hdr ^ pl_seed ^ 32'(idx);
        mem[idx] = {{(REGS_WIDTH/32){w}}, hdr};
    endfunction

    function automatic void fill_mem(input logic [31:0] hdr);
        for (int i = 0; i < PROGRAM_SIZE; i++) set_instr(i, hdr);
    endfunction

    // Program-level semantics: which instructions run, in what order.
    function automatic void model_run(input int len_raw);
        int len, p, cnt, steps;
        logic [31:0] h;
        len = (len_raw > PROGRAM_SIZE) ? PROGRAM_SIZE : len_raw;
        p = 0;
        cnt = 0;
        steps = 0;
        model_pcs.delete();
        model_err = 0;
        model_last = -1;
        model_fetches = 0;
        if (len == 0) return;
        while (steps < 10000) begin
            h = mem[p][31:0];
            steps++;
            model_fetches++;
            model_last = p;
            if (h[7:0] == 8'h00) return;
            if (h[7:0] == 8'h01) begin
`ifdef PIPEARCH_SEQ_LOOP_EN
                if (int'(h[12:8]) >= len) begin
                    model_err = 1;
                    return;
                end
                if (cnt < int'(h[31:16])) begin
                    cnt++;
                    p = int'(h[12:8]);
                    continue;
                end
                cnt = 0;
`else
                model_err = 1;
                return;
`endif
            end else begin
                model_pcs.push_back(p);
            end
            if (p + 1 == len) return;
            p++;
        end
    endfunction

    // observe DUT outputs one time unit after each rising edge
    initial forever begin
        @(posedge clk);
        #1;
        if (exec_start) begin
            n_exec++;
            exec_pcs.push_back(int'(pc));
            if (exec_regs !== mem[pc][IW-1:SEQ_HEADER_WIDTH]) n_regs_bad++;
        end
        if (prog_re) begin
            n_fetch++;
            if (prog_raddr !== pc) n_addr_bad++;
        end
        if (done) n_done++;
        if (state == 3'(INSTRUCTION_RECEIVE)) n_recv++;
        if (state == 3'(EXECUTE)) n_execcyc++;
    end

    // program memory: answers each read rd_lat cycles late
    initial forever begin
        logic [AW-1:0] a;
        @(posedge clk);
        #1;
        if (prog_re) begin
            a = prog_raddr;
            repeat (rd_lat) @(posedge clk);
            @(posedge clk);
            #1;
            prog_rdata  = mem[a];
            prog_rvalid = 1'b1;
            @(posedge clk);
            #1;
            prog_rvalid = 1'b0;
        end
    end

    // datapath: completion pulse exec_lat cycles after exec_start
    initial forever begin
        @(posedge clk);
        #1;
        if (exec_start) begin
            repeat (exec_lat - 1) @(posedge clk);
            @(posedge clk);
            #1;
            exec_done_resp = 1'b1;
            @(posedge clk);
            #1;
            exec_done_resp = 1'b0;
        end
    end

    task automatic snapshot();
        b_exec = n_exec; b_fetch = n_fetch; b_done = n_done; b_recv = n_recv;
        b_execcyc = n_execcyc; b_regs_bad = n_regs_bad; b_addr_bad = n_addr_bad;
        b_pcs = exec_pcs.size();
    endtask

    task automatic deltas();
        d_exec = n_exec - b_exec; d_fetch = n_fetch - b_fetch; d_done = n_done - b_done;
        d_recv = n_recv - b_recv; d_execcyc = n_execcyc - b_execcyc;
        d_regs_bad = n_regs_bad - b_regs_bad; d_addr_bad = n_addr_bad - b_addr_bad;
    endtask

    task automatic run_prog(input int len, output bit fin);
        snapshot();
        @(posedge clk);
        #1;
        start = 1'b1;
        program_length = len[AW:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        fin = 0;
        for (int i = 0; i < 5000 && !fin; i++) begin
            @(posedge clk);
            #1;
            if (done) fin = 1;
        end
        #2;
        deltas();
    endtask

    initial begin
        bit fin;
        bit inj_s;
        int len, sel, roll;
        bit has_jump;
        logic [31:0] h;

        tbl[0] = '{3,  {32'h20, 32'h12, 32'h11, 32'h10}, 3, 3, 0, 2};
        tbl[1] = '{0,  {32'h20, 32'h20, 32'h20, 32'h20}, 0, 0, 0, -1};
        tbl[2] = '{4,  {32'h20, 32'h20, 32'h00, 32'h10}, 1, 2, 0, 0};
        tbl[3] = '{4,  {32'h20, 32'h20, 32'h0000_0701, 32'h10}, 1, 2, 1, 0};
        tbl[4] = '{40, {32'h20, 32'h20, 32'h20, 32'h20}, 32, 32, 0, 31};
        tbl[5] = '{1,  {32'h20, 32'h20, 32'h20, 32'h33}, 1, 1, 0, 0};
`ifdef PIPEARCH_SEQ_LOOP_EN
        tbl[6] = '{2,  {32'h20, 32'h20, 32'h0002_0001, 32'h10}, 3, 6, 0, 0};
        tbl[7] = '{3,  {32'h20, 32'h12, 32'h0000_0001, 32'h10}, 2, 3, 0, 2};
`else
        tbl[6] = '{2,  {32'h20, 32'h20, 32'h0002_0001, 32'h10}, 1, 2, 1, 0};
        tbl[7] = '{3,  {32'h20, 32'h12, 32'h0000_0001, 32'h10}, 1, 2, 1, 0};
`endif

        fill_mem(32'h20);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_pc", pc, 0);
        check("rst_prog_re", prog_re, 0);
        check("rst_exec_start", exec_start, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_opcode", exec_opcode, 0);
        check("rst_regs_nonzero", longint'(exec_regs != '0), 0);
        reset_n = 1'b1;

        // directed vectors
        for (int v = 0; v < 8; v++) begin
            pl_seed = $urandom;
            fill_mem(32'h20);
            for (int j = 0; j < 4; j++) set_instr(j, tbl[v].hdr[j]);
            rd_lat = 1;
            exec_lat = 2;
            run_prog(tbl[v].len, fin);
            check($sformatf("vec%0d_finish", v), fin, 1);
            check($sformatf("vec%0d_execs", v), d_exec, tbl[v].execs);
            check($sformatf("vec%0d_fetches", v), d_fetch, tbl[v].fetches);
            check($sformatf("vec%0d_error", v), error, tbl[v].err);
            check($sformatf("vec%0d_done_count", v), d_done, 1);
            check($sformatf("vec%0d_payload_bad", v), d_regs_bad, 0);
            if (tbl[v].execs > 0 && d_exec > 0)
                check($sformatf("vec%0d_last_pc", v), exec_pcs[exec_pcs.size()-1], tbl[v].last_pc);
        end

        // length 0: done exactly two edges after start is sampled
        snapshot();
        @(posedge clk);
        #1;
        start = 1'b1;
        program_length = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("len0_state_done", state, 5);
        check("len0_done_early", done, 0);
        @(posedge clk);
        #1;
        check("len0_done_pulse", done, 1);
        check("len0_idle", state, 0);
        @(posedge clk);
        #1;
        check("len0_done_drop", done, 0);
        #2;
        deltas();
        check("len0_no_fetch", d_fetch, 0);
        check("len0_no_exec", d_exec, 0);

        // slow memory, stray start in RECEIVE, stray exec_done in DECODE and launch cycle
        pl_seed = $urandom;
        fill_mem(32'h20);
        set_instr(0, 32'h10);
        set_instr(1, 32'h11);
        rd_lat = 4;
        exec_lat = 3;
        snapshot();
        @(posedge clk);
        #1;
        start = 1'b1;
        program_length = 6'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        inj_s = 0;
        fin = 0;
        for (int i = 0; i < 400 && !fin; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            exec_done_inj = 1'b0;
            if (done) fin = 1;
            else if (state == 3'(INSTRUCTION_RECEIVE) && !inj_s) begin
                start = 1'b1;
                program_length = 6'd1;
                inj_s = 1;
            end else if (state == 3'(INSTRUCTION_DECODE)) exec_done_inj = 1'b1;
            else if (exec_start) exec_done_inj = 1'b1;
        end
        start = 1'b0;
        exec_done_inj = 1'b0;
        #2;
        deltas();
        check("stray_finish", fin, 1);
        check("stray_recv_cycles", d_recv, 10);
        check("stray_exec_cycles", d_execcyc, 8);
        check("stray_execs", d_exec, 2);
        check("stray_fetches", d_fetch, 2);
        check("stray_done_count", d_done, 1);
        if (d_exec == 2) begin
            check("stray_pc0", exec_pcs[b_pcs], 0);
            check("stray_pc1", exec_pcs[b_pcs+1], 1);
        end

        // asynchronous reset while executing the second instruction
        pl_seed = $urandom;
        fill_mem(32'h20);
        set_instr(0, 32'h10);
        set_instr(1, 32'h11);
        set_instr(2, 32'h12);
        rd_lat = 0;
        exec_lat = 3;
        snapshot();
        @(posedge clk);
        #1;
        start = 1'b1;
        program_length = 6'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        fin = 0;
        for (int i = 0; i < 200 && !fin; i++) begin
            @(posedge clk);
            #1;
            if (exec_start && pc == 1) fin = 1;
        end
        check("rstx_reached", fin, 1);
        reset_n = 1'b0;
        #1;
        check("rstx_state", state, 0);
        check("rstx_pc", pc, 0);
        check("rstx_exec_start", exec_start, 0);
        check("rstx_prog_re", prog_re, 0);
        check("rstx_done", done, 0);
        check("rstx_error", error, 0);
        check("rstx_opcode", exec_opcode, 0);
        check("rstx_regs_nonzero", longint'(exec_regs != '0), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        deltas();
        check("rstx_stays_idle", state, 0);
        check("rstx_no_done", d_done, 0);

        // random programs against the reference model
        for (int r = 0; r < 40; r++) begin
            pl_seed = $urandom;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) len = 0;
            else if (sel == 1) len = int'($urandom_range(33, 63));
            else len = int'($urandom_range(1, 10));
            has_jump = 0;
            for (int i = 0; i < PROGRAM_SIZE; i++) begin
                roll = int'($urandom_range(0, 15));
                if (roll == 0) h = {24'($urandom), 8'h00};
                else if (roll == 1 && !has_jump) begin
                    h = {16'($urandom_range(0, 3)), 3'b000, 5'($urandom_range(0, 11)), 8'h01};
                    has_jump = 1;
                end else h = {24'($urandom), 8'($urandom_range(2, 255))};
                set_instr(i, h);
            end
            rd_lat = int'($urandom_range(0, 3));
            exec_lat = int'($urandom_range(1, 3));
            model_run(len);
            run_prog(len, fin);
            check("rnd_finish", fin, 1);
            check("rnd_execs", d_exec, model_pcs.size());
            for (int i = 0; i < d_exec && i < model_pcs.size(); i++)
                check("rnd_pc", exec_pcs[b_pcs+i], model_pcs[i]);
            check("rnd_error", error, model_err);
            check("rnd_fetches", d_fetch, model_fetches);
            check("rnd_done_count", d_done, 1);
            check("rnd_payload_bad", d_regs_bad, 0);
            check("rnd_raddr_bad", d_addr_bad, 0);
            if (model_last >= 0) check("rnd_opcode_hold", exec_opcode, mem[model_last][7:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
